tcm_dport_arb: RTL

//  Two-master arbiter in front of the TCM data port. Master 0 is the core LSU
//  (tagged, may issue cache-maintenance ops); master 1 is the external

---
 rtl/tcm_dport_arb.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/tcm_dport_arb.sv
// Two-master round-robin arbiter for the TCM data port; an owner-ID FIFO
// routes in-order downstream responses back to the master that issued them.
module tcm_dport_arb #(
    parameter int unsigned TAG_W       = 11,
    parameter int unsigned OUTSTANDING = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      m0_addr_i,
    input  logic [31:0]      m0_data_wr_i,
    input  logic             m0_rd_i,
    input  logic [3:0]       m0_wr_i,
    input  logic [TAG_W-1:0] m0_req_tag_i,
    input  logic             m0_flush_i,
    input  logic             m0_invalidate_i,
    input  logic             m0_writeback_i,
    output logic             m0_accept_o,
    output logic             m0_ack_o,
    output logic [31:0]      m0_data_rd_o,
    output logic [TAG_W-1:0] m0_resp_tag_o,
    output logic             m0_error_o,
    input  logic [31:0]      m1_addr_i,
    input  logic [31:0]      m1_data_wr_i,
    input  logic             m1_rd_i,
    input  logic [3:0]       m1_wr_i,
    output logic             m1_accept_o,
    output logic             m1_ack_o,
    output logic             m1_error_o,
    output logic [31:0]      m1_data_rd_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_data_wr_o,
    output logic             mem_rd_o,
    output logic [3:0]       mem_wr_o,
    output logic [TAG_W-1:0] mem_req_tag_o,
    output logic             mem_flush_o,
    output logic             mem_invalidate_o,
    output logic             mem_writeback_o,
    input  logic             mem_accept_i,
    input  logic             mem_ack_i,
    input  logic             mem_error_i,
    input  logic [31:0]      mem_data_rd_i,
    input  logic [TAG_W-1:0] mem_resp_tag_i,
    output logic             err_unexp_o
);

    localparam int unsigned PtrW = $clog2(OUTSTANDING);
    localparam int unsigned CntW = PtrW + 1;

    logic [OUTSTANDING-1:0] owner_q, owner_d;
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]        count_q, count_d;
    logic                   prio_q, prio_d;
    logic                   err_q, err_d;

    logic req0, req1, gnt0, gnt1, full, empty, issue, pop, head_owner;

    // full is purely registered so an ack never feeds back into accept.
    always_comb begin
        req0       = m0_rd_i | (|m0_wr_i) | m0_flush_i | m0_invalidate_i | m0_writeback_i;
        req1       = m1_rd_i | (|m1_wr_i);
        gnt0       = req0 & (~req1 | ~prio_q);
        gnt1       = req1 & (~req0 | prio_q);
        full       = (count_q == CntW'(OUTSTANDING));
        empty      = (count_q == '0);
        issue      = (gnt0 | gnt1) & ~full & mem_accept_i;
        pop        = mem_ack_i & ~empty;
        head_owner = owner_q[rd_ptr_q];
    end

    always_comb begin
        mem_addr_o       = '0;
        mem_data_wr_o    = '0;
        mem_rd_o         = 1'b0;
        mem_wr_o         = '0;
        mem_req_tag_o    = '0;
        mem_flush_o      = 1'b0;
        mem_invalidate_o = 1'b0;
        mem_writeback_o  = 1'b0;
        if (gnt0 && !full) begin
            mem_addr_o       = m0_addr_i;
            mem_data_wr_o    = m0_data_wr_i;
            mem_rd_o         = m0_rd_i;
            mem_wr_o         = m0_wr_i;
            mem_req_tag_o    = m0_req_tag_i;
            mem_flush_o      = m0_flush_i;
            mem_invalidate_o = m0_invalidate_i;
            mem_writeback_o  = m0_writeback_i;
        end else if (gnt1 && !full) begin
            mem_addr_o    = m1_addr_i;
            mem_data_wr_o = m1_data_wr_i;
            mem_rd_o      = m1_rd_i;
            mem_wr_o      = m1_wr_i;
        end
    end

    always_comb begin
        m0_accept_o   = ~full & mem_accept_i & (~req1 | ~prio_q);
        m1_accept_o   = ~full & mem_accept_i & (~req0 | prio_q);
        m0_ack_o      = pop & ~head_owner;
        m1_ack_o      = pop & head_owner;
        m0_error_o    = m0_ack_o & mem_error_i;
        m1_error_o    = m1_ack_o & mem_error_i;
        m0_data_rd_o  = mem_data_rd_i;
        m1_data_rd_o  = mem_data_rd_i;
        m0_resp_tag_o = mem_resp_tag_i;
        err_unexp_o   = err_q;
    end

    always_comb begin
        owner_d  = owner_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        prio_d   = prio_q;
        err_d    = err_q | (mem_ack_i & empty);
        if (issue) begin
            owner_d[wr_ptr_q] = gnt1;
            wr_ptr_d          = wr_ptr_q + PtrW'(1);
            prio_d            = ~gnt1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (issue && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!issue && pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            owner_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            prio_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            owner_q  <= owner_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            prio_q   <= prio_d;
            err_q    <= err_d;
        end
    end

endmodule
